// File: rtl/i_fetch.sv
// ---------------------------------------------------------------------------
// i_fetch : instruction fetch unit for the bfcpu core
//
// Fetches opcode bytes from instruction memory one request at a time,
// buffers them with their PC in a small prefetch FIFO, and presents the
// FIFO head to the decoder through a valid/ready handshake. The decoder
// can redirect fetch when it resolves a '[' or ']' jump.
//
// Parameters
//   i_addr_width  width of the PC and of i_addr
//   fifo_depth    prefetch FIFO entries (power of two, >= 2)
//   reset_pc      first fetch address after reset
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   redirect, redirect_addr     decoder jump: restart fetch at redirect_addr
//   instr_valid/data/pc         FIFO head presented to the decoder
//   instr_ready                 decoder pops the head when valid && ready
//   halted                      fetch stopped on a 0x00 byte
//   i_req, i_addr               request port to instruction memory
//   i_ack, i_rdata              memory acknowledge and fetched byte
//
// Build option
//   IFETCH_HALT_ON_ZERO_EN  when defined, an acked 0x00 byte is not
//   buffered; fetch stops in HALT until redirect or reset. When undefined,
//   0x00 is an ordinary byte and halted is tied low.
// ---------------------------------------------------------------------------
module i_fetch #(
  parameter int                      i_addr_width = 16,
  parameter int                      fifo_depth   = 4,
  parameter logic [i_addr_width-1:0] reset_pc     = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    redirect,
  input  logic [i_addr_width-1:0] redirect_addr,
  output logic                    instr_valid,
  output logic [7:0]              instr_data,
  output logic [i_addr_width-1:0] instr_pc,
  input  logic                    instr_ready,
  output logic                    halted,
  output logic                    i_req,
  output logic [i_addr_width-1:0] i_addr,
  input  logic                    i_ack,
  input  logic [7:0]              i_rdata
);

  localparam int ptr_w = $clog2(fifo_depth);
  localparam int cnt_w = ptr_w + 1;

  localparam logic [cnt_w-1:0]        depth_c = cnt_w'(fifo_depth);
  localparam logic [cnt_w-1:0]        cnt_one = cnt_w'(1);
  localparam logic [ptr_w-1:0]        ptr_one = ptr_w'(1);
  localparam logic [i_addr_width-1:0] pc_one  = i_addr_width'(1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    BUBBLE,
    HALT
  } state_t;

  state_t state;
  state_t next_state;

  logic [7:0]              fifo_data [fifo_depth];
  logic [i_addr_width-1:0] fifo_pc   [fifo_depth];
  logic [ptr_w-1:0]        wr_ptr;
  logic [ptr_w-1:0]        rd_ptr;
  logic [cnt_w-1:0]        count;
  logic [cnt_w-1:0]        count_next;
  logic [i_addr_width-1:0] fetch_pc;

  logic accept;
  logic push;
  logic pop;
`ifdef IFETCH_HALT_ON_ZERO_EN
  logic halt_set;
  logic halted_q;
`endif

  // State register for the fetch sequencer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and request logic. Acks only count while a request is
  // actually being driven, so acks arriving in IDLE/BUBBLE/HALT (stale
  // responses to abandoned or completed requests) are ignored. The space
  // decision uses the registered count adjusted by this edge's push and
  // pop, so instr_ready never reaches i_req combinationally (i_req is a
  // pure decode of the state register).
  always_comb begin
    accept     = (state == REQ) && i_ack && !redirect;
    push       = accept;
`ifdef IFETCH_HALT_ON_ZERO_EN
    halt_set   = accept && (i_rdata == 8'h00);
    push       = accept && (i_rdata != 8'h00);
`endif
    pop        = (count != '0) && instr_ready && !redirect;
    count_next = count;
    i_req      = (state == REQ);
    next_state = state;

    case ({push, pop})
      2'b10:   count_next = count + cnt_one;
      2'b01:   count_next = count - cnt_one;
      default: count_next = count;
    endcase

    if (redirect) begin
      next_state = BUBBLE;
    end else begin
      case (state)
        IDLE: begin
          if (count_next < depth_c) next_state = REQ;
        end
        REQ: begin
          if (count_next >= depth_c) next_state = IDLE;
`ifdef IFETCH_HALT_ON_ZERO_EN
          if (halt_set) next_state = HALT;
`endif
        end
        BUBBLE: begin
          next_state = REQ;
        end
`ifdef IFETCH_HALT_ON_ZERO_EN
        HALT: begin
          next_state = HALT;
        end
`endif
        default: begin
          next_state = IDLE;
        end
      endcase
    end
  end

  // Fetch PC and FIFO bookkeeping. A redirect wipes the FIFO and discards
  // both the ack and the pop of its own cycle. The PC wraps silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= reset_pc;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_addr;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + ptr_one;
        fetch_pc <= fetch_pc + pc_one;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ptr_one;
      end
      count <= count_next;
    end
  end

  // FIFO storage. No reset needed: entries are only observable while
  // count says they are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= i_rdata;
      fifo_pc[wr_ptr]   <= fetch_pc;
    end
  end

`ifdef IFETCH_HALT_ON_ZERO_EN
  // Halt flag: set by a zero opcode, cleared only by redirect or reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      halted_q <= 1'b0;
    end else if (redirect) begin
      halted_q <= 1'b0;
    end else if (halt_set) begin
      halted_q <= 1'b1;
    end
  end

  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  // Decoder-facing outputs come straight from FIFO registers; they are
  // forced to zero when empty so reset leaves them at zero.
  always_comb begin
    instr_valid = (count != '0);
    instr_data  = 8'h00;
    instr_pc    = '0;
    if (instr_valid) begin
      instr_data = fifo_data[rd_ptr];
      instr_pc   = fifo_pc[rd_ptr];
    end
  end

  assign i_addr = fetch_pc;

endmodule

// File: tb/tb_i_fetch.sv
// ---------------------------------------------------------------------------
// tb_i_fetch : self-checking bench for i_fetch
//
// A behavioural memory answers requests one cycle after it sees them, with
// optional random stalls. The reference model tracks the instruction
// stream at the level of "which PC should the decoder see next", the
// occupancy of the prefetch buffer and the next fetch address, and is
// updated from the handshakes each cycle. A second instance with
// reset_pc = 0xFFFE exercises PC wrap-around.
// ---------------------------------------------------------------------------
module tb_i_fetch;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [15:0] redirect_addr = 16'h0000;
  logic        instr_valid;
  logic [7:0]  instr_data;
  logic [15:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic        halted;
  logic        i_req;
  logic [15:0] i_addr;
  logic        i_ack;
  logic [7:0]  i_rdata;

  logic        wrap_valid;
  logic [7:0]  wrap_data;
  logic [15:0] wrap_pc;
  logic        wrap_halted;
  logic        wrap_req;
  logic [15:0] wrap_addr;
  logic        wrap_ack;
  logic [7:0]  wrap_rdata;

  logic [7:0]  mem [65536];
  logic        stall_en = 1'b0;
  logic        ack_q = 1'b0;
  logic        wrap_ack_q = 1'b0;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_pc;
  logic [15:0] fpc;
  int          occ;
  logic        m_halted;

  i_fetch #(.i_addr_width(16), .fifo_depth(DEPTH), .reset_pc(16'h0000)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_addr(redirect_addr),
    .instr_valid(instr_valid), .instr_data(instr_data), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .halted(halted), .i_req(i_req), .i_addr(i_addr),
    .i_ack(i_ack), .i_rdata(i_rdata)
  );

  i_fetch #(.i_addr_width(16), .fifo_depth(DEPTH), .reset_pc(16'hFFFE)) dut_wrap (
    .clk(clk), .rst(rst), .redirect(1'b0), .redirect_addr(16'h0000),
    .instr_valid(wrap_valid), .instr_data(wrap_data), .instr_pc(wrap_pc),
    .instr_ready(1'b1), .halted(wrap_halted), .i_req(wrap_req), .i_addr(wrap_addr),
    .i_ack(wrap_ack), .i_rdata(wrap_rdata)
  );

  always #5 clk = ~clk;

  // Memory: acknowledges one cycle after seeing a request, data follows
  // the current address.
  assign i_ack      = ack_q;
  assign i_rdata    = mem[i_addr];
  assign wrap_ack   = wrap_ack_q;
  assign wrap_rdata = mem[wrap_addr];

  always @(posedge clk) begin
    ack_q      <= i_req && (!stall_en || ($urandom_range(0, 3) != 0));
    wrap_ack_q <= wrap_req;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock of stimulus: update the model from the handshakes seen
  // before the edge, then check the DUT after the edge.
  task automatic applyStimulus(input logic rdy, input logic redir, input logic [15:0] raddr);
    logic        pend;
    logic        acc;
    logic [15:0] addr_before;
    instr_ready   = rdy;
    redirect      = redir;
    redirect_addr = raddr;
    pend          = i_req && !i_ack && !redir;
    acc           = i_req && i_ack && !redir;
    addr_before   = i_addr;
    if (instr_valid && rdy && !redir) begin
      checkOutput("pop_pc", 32'(instr_pc), 32'(exp_pc));
      checkOutput("pop_data", 32'(instr_data), 32'(mem[exp_pc]));
      exp_pc++;
    end
    if (redir) begin
      occ      = 0;
      fpc      = raddr;
      exp_pc   = raddr;
      m_halted = 1'b0;
    end else begin
      if (instr_valid && rdy) occ--;
      if (acc) begin
`ifdef IFETCH_HALT_ON_ZERO_EN
        if (mem[fpc] == 8'h00) begin
          m_halted = 1'b1;
        end else begin
          occ++;
          fpc++;
        end
`else
        occ++;
        fpc++;
`endif
      end
    end
    @(posedge clk);
    #1;
    checkOutput("valid", 32'(instr_valid), 32'(occ != 0));
    checkOutput("occ_bound", 32'(occ <= DEPTH), 32'd1);
    checkOutput("halted", 32'(halted), 32'(m_halted));
    if (i_req) checkOutput("fetch_addr", 32'(i_addr), 32'(fpc));
    if (occ == DEPTH) checkOutput("full_req", 32'(i_req), 32'd0);
    if (m_halted) checkOutput("halt_req", 32'(i_req), 32'd0);
    if (pend) checkOutput("req_hold", {15'd0, i_req, i_addr}, {15'd0, 1'b1, addr_before});
  endtask

  task automatic resetDut();
    rst         = 1'b1;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_req", 32'(i_req), 32'd0);
    checkOutput("rst_addr", 32'(i_addr), 32'h0000);
    checkOutput("rst_valid", 32'(instr_valid), 32'd0);
    checkOutput("rst_data", 32'(instr_data), 32'd0);
    checkOutput("rst_pc", 32'(instr_pc), 32'd0);
    checkOutput("rst_halted", 32'(halted), 32'd0);
    rst      = 1'b0;
    exp_pc   = 16'h0000;
    fpc      = 16'h0000;
    occ      = 0;
    m_halted = 1'b0;
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom_range(1, 255));
    mem[0]       = 8'h2B;
    mem[1]       = 8'h3E;
    mem[2]       = 8'h2D;
    mem[3]       = 8'h3C;
    mem[16'h100] = 8'h2B;
    mem[16'h101] = 8'h2B;
    mem[16'h102] = 8'h00;

    // Reset release and "+>-<" streamed on consecutive cycles; the
    // wrap instance streams 0xFFFE, 0xFFFF, 0x0000 alongside.
    resetDut();
    applyStimulus(1'b1, 1'b0, 16'h0);
    checkOutput("t1_req_e0", 32'(i_req), 32'd1);
    checkOutput("t1_addr_e0", 32'(i_addr), 32'h0);
    applyStimulus(1'b1, 1'b0, 16'h0);
    checkOutput("t1_valid_e1", 32'(instr_valid), 32'd0);
    applyStimulus(1'b1, 1'b0, 16'h0);
    checkOutput("t1_valid_e2", 32'(instr_valid), 32'd1);
    checkOutput("t1_pc_e2", 32'(instr_pc), 32'h0);
    checkOutput("t1_data_e2", 32'(instr_data), 32'h2B);
    checkOutput("wrap_pc0", 32'(wrap_pc), 32'hFFFE);
    checkOutput("wrap_valid0", 32'(wrap_valid), 32'd1);
    applyStimulus(1'b1, 1'b0, 16'h0);
    checkOutput("t1_pc_e3", 32'(instr_pc), 32'h1);
    checkOutput("wrap_pc1", 32'(wrap_pc), 32'hFFFF);
    applyStimulus(1'b1, 1'b0, 16'h0);
    checkOutput("t1_pc_e4", 32'(instr_pc), 32'h2);
    checkOutput("wrap_pc2", 32'(wrap_pc), 32'h0000);
    checkOutput("wrap_data2", 32'(wrap_data), 32'(mem[0]));
    applyStimulus(1'b1, 1'b0, 16'h0);
    checkOutput("t1_pc_e5", 32'(instr_pc), 32'h3);
    checkOutput("t1_data_e5", 32'(instr_data), 32'h3C);

    // Stalled decoder: the buffer fills with pc 0..3 and fetch stops.
    resetDut();
    for (int k = 0; k < 12; k++) applyStimulus(1'b0, 1'b0, 16'h0);
    checkOutput("t2_req_full", 32'(i_req), 32'd0);
    checkOutput("t2_next_addr", 32'(i_addr), 32'h4);
    checkOutput("t2_head_pc", 32'(instr_pc), 32'h0);
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1'b1, 1'b0, 16'h0);
      checkOutput("t2_stream", 32'(instr_valid), 32'd1);
    end
    checkOutput("t2_pops", 32'(exp_pc), 32'd12);

    // Redirect coinciding with the ack for pc 5.
    resetDut();
    for (int k = 0; k < 40 && !(i_req && i_ack && i_addr == 16'h5); k++)
      applyStimulus(1'b1, 1'b0, 16'h0);
    checkOutput("t3_ack_pc5_seen", 32'(i_req && i_ack && (i_addr == 16'h5)), 32'd1);
    applyStimulus(1'b1, 1'b1, 16'h0010);
    checkOutput("t3_empty_r", 32'(instr_valid), 32'd0);
    checkOutput("t3_req_r", 32'(i_req), 32'd0);
    applyStimulus(1'b1, 1'b0, 16'h0);
    checkOutput("t3_req_r1", 32'(i_req), 32'd1);
    checkOutput("t3_addr_r1", 32'(i_addr), 32'h0010);
    checkOutput("t3_valid_r1", 32'(instr_valid), 32'd0);
    applyStimulus(1'b1, 1'b0, 16'h0);
    checkOutput("t3_valid_r2", 32'(instr_valid), 32'd0);
    applyStimulus(1'b1, 1'b0, 16'h0);
    checkOutput("t3_valid_r3", 32'(instr_valid), 32'd1);
    checkOutput("t3_pc_r3", 32'(instr_pc), 32'h0010);

    // Zero opcode at 0x102 after "++" at 0x100.
    applyStimulus(1'b1, 1'b1, 16'h0100);
`ifdef IFETCH_HALT_ON_ZERO_EN
    for (int k = 0; k < 8; k++) applyStimulus(1'b1, 1'b0, 16'h0);
    checkOutput("t5_halted", 32'(halted), 32'd1);
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b1, 1'b0, 16'h0);
      checkOutput("t5_req_low", 32'(i_req), 32'd0);
    end
    checkOutput("t5_delivered", 32'(exp_pc), 32'h0102);
    applyStimulus(1'b1, 1'b1, 16'h0000);
    checkOutput("t5_unhalt", 32'(halted), 32'd0);
    applyStimulus(1'b1, 1'b0, 16'h0);
    checkOutput("t5_resume_req", 32'(i_req), 32'd1);
    checkOutput("t5_resume_addr", 32'(i_addr), 32'h0000);
`else
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, 1'b0, 16'h0);
      checkOutput("t5_no_halt", 32'(halted), 32'd0);
    end
    checkOutput("t5_zero_passed", 32'(exp_pc > 16'h0102), 32'd1);
`endif

    // Reset while a request is pending and three entries are buffered.
    resetDut();
    for (int k = 0; k < 20 && occ != 3; k++) applyStimulus(1'b0, 1'b0, 16'h0);
    checkOutput("t6_occ3", 32'(occ), 32'd3);
    checkOutput("t6_req_pending", 32'(i_req), 32'd1);
    resetDut();
    applyStimulus(1'b1, 1'b0, 16'h0);
    checkOutput("t6_stale_ack", 32'(instr_valid), 32'd0);
    for (int k = 0; k < 6; k++) applyStimulus(1'b1, 1'b0, 16'h0);
    checkOutput("t6_restart", 32'(exp_pc), 32'd4);

    // Random traffic: decoder stalls, memory stalls, occasional jumps.
    resetDut();
    stall_en = 1'b1;
    for (int k = 0; k < 800; k++) begin
      logic        rdy;
      logic        redir;
      logic [15:0] raddr;
      rdy   = 1'($urandom_range(0, 1));
      redir = ($urandom_range(0, 39) == 0);
      raddr = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'hFFFC + 16'($urandom_range(0, 3));
      applyStimulus(rdy, redir, raddr);
    end
    stall_en = 1'b0;
    for (int k = 0; k < 10; k++) applyStimulus(1'b1, 1'b0, 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i_fetch.md
# i_fetch

Instruction fetch unit for the bfcpu core. It sits directly upstream of the instruction memory: it drives the `i_req`/`i_addr` request port, accepts `i_ack`/`i_rdata`, and buffers fetched opcode bytes in a small prefetch FIFO. It presents them to the decoder with a valid/ready handshake, tagged with their PC. The decoder redirects it when it resolves a `[` or `]` jump.

## Interface
- `i_addr_width`, 16: width of the PC and of `i_addr`.
- `fifo_depth`, 4: prefetch FIFO entries; a power of two, minimum 2.
- `reset_pc`, 0: first fetch address after reset.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `redirect`  in  1  single-cycle pulse from the decoder: restart fetch at `redirect_addr`.
- `redirect_addr`  in  `i_addr_width`  new fetch PC.
- `instr_valid`  out  1  FIFO head is valid.
- `instr_data`  out  8  opcode byte at FIFO head.
- `instr_pc`  out  `i_addr_width`  address of `instr_data`.
- `instr_ready`  in  1  decoder pops the head when `instr_valid && instr_ready`.
- `halted`  out  1  fetch stopped on a 0x00 byte (see Configuration).
- `i_req`  out  1  fetch request to instruction memory.
- `i_addr`  out  `i_addr_width`  fetch address.
- `i_ack`  in  1  memory: `i_rdata` holds the byte for the current `i_addr`.
- `i_rdata`  in  8  fetched byte.

## Operation
- State:
  - `fetch_pc`, which drives `i_addr`.
  - FIFO of {byte, pc} with a count of 0..`fifo_depth`.
  - FSM with states IDLE, REQ, BUBBLE and HALT.
- Request protocol:
  - At most one request is outstanding.
  - While `i_req` is high, `i_addr` stays stable until `i_ack` is sampled high.
  - On an ack edge the byte and `fetch_pc` are written to the FIFO and `fetch_pc` increments.
  - `i_req` stays high with the new address if space remains, which gives back-to-back fetches of 1 byte/cycle.
- Space rule: a request is issued or kept only while count, after this edge's push and pop, is below `fifo_depth`. A full FIFO drops `i_req` to 0; state goes to IDLE.
- IDLE → REQ when space exists.
- PC arithmetic: modulo 2^`i_addr_width`. `fetch_pc` at all-ones wraps to 0 and no flag is raised.
- Redirect (highest priority):
  - On a `redirect` edge: FIFO cleared, `fetch_pc` ← `redirect_addr`, `halted` ← 0, state → BUBBLE.
  - An `i_ack` in the redirect cycle is discarded.
  - A pop in the redirect cycle is discarded.
- BUBBLE: `i_req` = 0 for exactly one cycle, which retires the abandoned request, then → REQ.
- Simultaneous push and pop: count is unchanged. Data order is preserved.
- FIFO empty: `instr_valid` = 0 and `instr_data`/`instr_pc` are don't-care. Pop while empty is ignored.
- Reset mid-request: any pending ack is ignored. Everything returns to reset values.

## Timing
- Reset values: `i_req` 0, `i_addr` = `reset_pc`, `instr_valid` 0, `instr_data` 0, `instr_pc` 0, `halted` 0, FIFO empty, state IDLE.
- Edge E0 is the first edge with `rst` low. `i_req` = 1 after E0. `i_ack` is high in the cycle after E1. `instr_valid` = 1 after E2.
- Ack-to-visible latency: 1 edge. The FIFO output is registered; there is no combinational path from `i_rdata` to `instr_data`.
- Redirect at edge R:
  - `i_req` = 0 in the cycle after R.
  - `i_req` = 1 with `redirect_addr` after R+1.
  - The first new `instr_valid` appears after R+3.
- `instr_ready` has no combinational path to `i_req`. The space decision uses registered count plus this edge's pop.

## Configuration
- `IFETCH_HALT_ON_ZERO_EN` defined:
  - An acked byte of 0x00 is not written to the FIFO and `fetch_pc` is not incremented.
  - `halted` ← 1 and state → HALT, where `i_req` = 0.
  - Bytes already in the FIFO still drain.
  - Only `redirect` or `rst` leaves HALT.
- Not defined:
  - 0x00 is treated as an ordinary byte.
  - `halted` is tied to 0.
  - HALT state logic is absent.

## Test plan
- Reset release, memory preloaded with "+>-<", `instr_ready` = 1 → `i_req` rises after E0; `instr_valid` after E2; the decoder sees 0x2B@0, 0x3E@1, 0x2D@2 and 0x3C@3 on consecutive cycles.
- `instr_ready` = 0 with `fifo_depth` = 4 → exactly 4 bytes fetched (pc 0..3), then `i_req` = 0. Raise `instr_ready` → one pop per cycle and refetch from pc 4 with no lost or duplicate byte.
- `redirect` with `redirect_addr` = 0x0010 pulsed in the same cycle as `i_ack` for pc 5 → byte for pc 5 dropped, FIFO empty, one-cycle `i_req` bubble, next `instr_pc` = 0x0010.
- `reset_pc` = 0xFFFE, `i_addr_width` = 16 → `instr_pc` sequence 0xFFFE, 0xFFFF, 0x0000.
- With `IFETCH_HALT_ON_ZERO_EN`, program "++" then 0x00 → two bytes delivered, `halted` = 1, `i_req` stays 0 for 20 cycles. `redirect` to 0 → `halted` = 0 and fetch resumes at 0.
- Assert `rst` while `i_req` = 1 and the FIFO holds 3 entries → after that edge all outputs are at reset values and the next ack is ignored.
